// File: rtl/pattern_sched_pkg.sv
// Shared types and sizing for the pattern scheduler and its 0-then-1 detector.
package pattern_sched_pkg;

  localparam int N_REQ = 4;
  localparam int W     = 8;
  localparam int ID_W  = 2;
  localparam int CNT_W = 3;
  localparam int BIT_W = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    FLUSH = 2'd2,
    DONE  = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    START = 2'd0,
    SAW0  = 2'd1,
    SAW01 = 2'd2
  } det_state_e;

  // Round-robin pick: nearest asserted request after last; last itself ranks lowest.
  function automatic logic [ID_W-1:0] rr_pick(input logic [N_REQ-1:0] req,
                                              input logic [ID_W-1:0]  last);
    logic [ID_W-1:0] idx;
    rr_pick = last;
    for (int i = N_REQ; i >= 1; i--) begin
      idx = last + i[ID_W-1:0];
      if (req[idx]) begin
        rr_pick = idx;
      end else begin
        rr_pick = rr_pick;
      end
    end
  endfunction

endpackage

// File: rtl/pattern_sched_detect.sv
// Moore recogniser for a 0 followed by a 1 on a serial bit stream.
module pattern_detect_01 (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic a,
  output logic y
);
  import pattern_sched_pkg::*;

  det_state_e state_q, state_d;
  logic       y_q, y_d;

  // Next-state and output decode
  always_comb begin
    state_d = state_q;
    if (clr) begin
      state_d = START;
    end else begin
      case (state_q)
        START:   state_d = a ? START : SAW0;
        SAW0:    state_d = a ? SAW01 : SAW0;
        SAW01:   state_d = a ? START : SAW0;
        default: state_d = START;
      endcase
    end
    y_d = (state_d == SAW01);
  end

  // Detector state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= START;
      y_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      y_q     <= y_d;
    end
  end

  assign y = y_q;

endmodule

// File: rtl/pattern_sched.sv
// Round-robin job scheduler: serialises the winner's word MSB first through
// the 0-then-1 detector and reports how many such pairs it contained.
module pattern_sched #(
  parameter int N_REQ = pattern_sched_pkg::N_REQ,
  parameter int W     = pattern_sched_pkg::W
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [N_REQ-1:0]          req,
  input  logic [N_REQ-1:0][W-1:0]   data_in,
  output logic [N_REQ-1:0]          grant,
  output logic                      busy,
  output logic                      done,
  output logic [1:0]                done_id,
  output logic [2:0]                count
);
  import pattern_sched_pkg::*;

  state_e           state_q, state_d;
  logic [N_REQ-1:0] grant_q, grant_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [ID_W-1:0]  done_id_q, done_id_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [ID_W-1:0]  last_id_q, last_id_d;
  logic [ID_W-1:0]  job_id_q, job_id_d;
  logic [W-1:0]     word_q, word_d;
  logic [BIT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic [CNT_W-1:0] acc_q, acc_d;
  logic [ID_W-1:0]  pick_s;
  logic             det_clr_s;
  logic             det_a_s;
  logic             det_y_s;

  // Detector is held cleared while idle so every job starts from START.
  assign det_clr_s = (state_q == IDLE);
  assign det_a_s   = word_q[3'd7 - bit_cnt_q];
  assign pick_s    = rr_pick(req, last_id_q);

  pattern_detect_01 u_detect (
    .clk   (clk),
    .reset (reset),
    .clr   (det_clr_s),
    .a     (det_a_s),
    .y     (det_y_s)
  );

  // Scheduler next-state logic
  always_comb begin
    state_d   = state_q;
    grant_d   = {N_REQ{1'b0}};
    done_d    = 1'b0;
    done_id_d = done_id_q;
    count_d   = count_q;
    last_id_d = last_id_q;
    job_id_d  = job_id_q;
    word_d    = word_q;
    bit_cnt_d = bit_cnt_q;
    acc_d     = acc_q;
    case (state_q)
      IDLE: begin
        if (req != {N_REQ{1'b0}}) begin
          state_d   = SHIFT;
          grant_d   = {{(N_REQ-1){1'b0}}, 1'b1} << pick_s;
          word_d    = data_in[pick_s];
          job_id_d  = pick_s;
          bit_cnt_d = {BIT_W{1'b0}};
          acc_d     = {CNT_W{1'b0}};
        end else begin
          state_d = IDLE;
        end
      end
      SHIFT: begin
        // y in the first shift cycle still reflects the cleared detector.
        if (bit_cnt_q != {BIT_W{1'b0}}) begin
          acc_d = acc_q + {{(CNT_W-1){1'b0}}, det_y_s};
        end else begin
          acc_d = acc_q;
        end
        if (bit_cnt_q == 3'd7) begin
          state_d = FLUSH;
        end else begin
          bit_cnt_d = bit_cnt_q + 3'd1;
        end
      end
      FLUSH: begin
        state_d   = DONE;
        count_d   = acc_q + {{(CNT_W-1){1'b0}}, det_y_s};
        done_d    = 1'b1;
        done_id_d = job_id_q;
      end
      DONE: begin
        state_d   = IDLE;
        last_id_d = done_id_q;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    busy_d = (state_d != IDLE);
  end

  // Scheduler state and registered outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      grant_q   <= {N_REQ{1'b0}};
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      done_id_q <= {ID_W{1'b0}};
      count_q   <= {CNT_W{1'b0}};
      last_id_q <= 2'd3;
      job_id_q  <= {ID_W{1'b0}};
      word_q    <= {W{1'b0}};
      bit_cnt_q <= {BIT_W{1'b0}};
      acc_q     <= {CNT_W{1'b0}};
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      done_id_q <= done_id_d;
      count_q   <= count_d;
      last_id_q <= last_id_d;
      job_id_q  <= job_id_d;
      word_q    <= word_d;
      bit_cnt_q <= bit_cnt_d;
      acc_q     <= acc_d;
    end
  end

  assign grant   = grant_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign done_id = done_id_q;
  assign count   = count_q;

endmodule
